quad_encoder_counter: RTL and testbench

//  Per-axis quadrature encoder front end feeding a 32-bit quad PIO input of the HPS/FPGA system.
//  - Synchronises and de-glitches raw A/B encoder pins.
//  - Performs X4 decode into a signed 32-bit position and a windowed velocity.
//  - Flags illegal transitions.
//  - The HPS clears the position through its bit of the quad-reset PIO.
//  - One instance per encoder channel.

---
 rtl/quad_encoder_counter_if.sv | 38 +++
 rtl/quad_encoder_counter.sv | 210 +++++++++++++++++++++
 tb/tb_quad_encoder_counter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_encoder_counter_if.sv
// -----------------------------------------------------------------------------
// quad_encoder_counter_if
//   Groups the pin-side inputs and the PIO-side results of one quadrature
//   encoder channel.
//   master : drives the raw encoder pins and the quad-reset (clear) bit,
//            and observes the decoded results.
//   slave  : the encoder counter itself.
//   Signals:
//     enc_a, enc_b : raw encoder channels A/B (asynchronous to clk)
//     clear        : level; high holds position/velocity/error state at 0
//     count        : signed 32-bit position (two's complement)
//     velocity     : signed net steps in the last completed window
//     vel_valid    : one-cycle pulse when velocity updates
//     dir          : direction of the last legal step (1 = up)
//     err          : sticky illegal-transition flag
//     err_cnt      : saturating illegal-transition count
// -----------------------------------------------------------------------------
interface quad_encoder_counter_if;
  logic        enc_a;
  logic        enc_b;
  logic        clear;
  logic [31:0] count;
  logic [31:0] velocity;
  logic        vel_valid;
  logic        dir;
  logic        err;
  logic [7:0]  err_cnt;

  modport master (
    output enc_a, enc_b, clear,
    input  count, velocity, vel_valid, dir, err, err_cnt
  );

  modport slave (
    input  enc_a, enc_b, clear,
    output count, velocity, vel_valid, dir, err, err_cnt
  );
endinterface

// File: rtl/quad_encoder_counter.sv
// -----------------------------------------------------------------------------
// quad_encoder_counter
//   Quadrature encoder front end for one axis. Raw A/B pins are brought into
//   the clk domain with a 2-FF synchroniser, de-glitched by a per-channel
//   stability filter, then X4-decoded into a signed 32-bit position and a
//   windowed velocity. Transitions where both filtered channels change at
//   once are flagged as illegal.
//
//   Pin edge to count update is FILTER_LEN+3 clk cycles:
//     2 (synchroniser) + FILTER_LEN (filter) + 1 (decode/count register).
//
//   Parameters:
//     FILTER_LEN : stable cycles required before a filtered level changes (>=1)
//     VEL_WINDOW : velocity window length in clk cycles (>=2)
//     INVERT_DIR : 1 swaps the count direction
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-high reset
//     bus   : slave side of quad_encoder_counter_if (pins, clear, results)
// -----------------------------------------------------------------------------
module quad_encoder_counter #(
  parameter int FILTER_LEN = 4,
  parameter int VEL_WINDOW = 50000,
  parameter bit INVERT_DIR = 1'b0
) (
  input logic                    clk,
  input logic                    reset,
  quad_encoder_counter_if.slave  bus
);

  // Filter counter only needs to reach FILTER_LEN-1; the cycle that would make
  // it FILTER_LEN is the one that accepts the new level.
  localparam int FCW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam int WCW = $clog2(VEL_WINDOW);
  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(VEL_WINDOW - 1);

  localparam logic [31:0] STEP_UP   = 32'h0000_0001;
  localparam logic [31:0] STEP_DOWN = 32'hFFFF_FFFF;
  localparam logic [31:0] STEP_NONE = 32'h0000_0000;

  // Maps a Gray-coded {a,b} pair onto its position in the forward sequence
  // 00 -> 01 -> 11 -> 10, so a legal step is a difference of +/-1 modulo 4.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    logic [1:0] pos;
    case (ab)
      2'b00:   pos = 2'd0;
      2'b01:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      2'b10:   pos = 2'd3;
      default: pos = 2'd0;
    endcase
    return pos;
  endfunction

  // Channel index 1 = A, 0 = B throughout.
  logic [1:0]     raw_s;
  logic [1:0]     sync1_r;
  logic [1:0]     sync2_r;
  logic [1:0]     filt_r;
  logic [FCW-1:0] fcnt_r [2];

  logic [1:0]     prev_ab_r;
  logic [1:0]     diff_s;
  logic           step_valid_s;
  logic           illegal_s;
  logic           up_s;
  logic [31:0]    step_s;

  logic [31:0]    count_r;
  logic [31:0]    velocity_r;
  logic [31:0]    acc_r;
  logic [WCW-1:0] win_r;
  logic           vel_valid_r;
  logic           dir_r;
  logic           err_r;
  logic [7:0]     err_cnt_r;

  assign raw_s = {bus.enc_a, bus.enc_b};

  // Two-stage synchroniser for the asynchronous encoder pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Glitch filter: a channel's level is accepted only after the synchronised
  // value has differed from the filtered one for FILTER_LEN consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_r <= 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        fcnt_r[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (sync2_r[ch] != filt_r[ch]) begin
          if (fcnt_r[ch] == FLT_LAST) begin
            filt_r[ch] <= sync2_r[ch];
            fcnt_r[ch] <= '0;
          end else begin
            fcnt_r[ch] <= fcnt_r[ch] + FCW'(1);
          end
        end else begin
          fcnt_r[ch] <= '0;
        end
      end
    end
  end

  // X4 decode of the filtered pair against the previously seen pair.
  always_comb begin
    diff_s       = gray_pos(filt_r) - gray_pos(prev_ab_r);
    step_valid_s = 1'b0;
    illegal_s    = 1'b0;
    up_s         = 1'b0;
    case (diff_s)
      2'd1: begin
        step_valid_s = 1'b1;
        up_s         = !INVERT_DIR;
      end
      2'd3: begin
        step_valid_s = 1'b1;
        up_s         = INVERT_DIR;
      end
      2'd2: begin
        illegal_s    = 1'b1;
      end
      default: begin
        step_valid_s = 1'b0;
        illegal_s    = 1'b0;
      end
    endcase
    if (step_valid_s) begin
      step_s = up_s ? STEP_UP : STEP_DOWN;
    end else begin
      step_s = STEP_NONE;
    end
  end

  // Decode history follows the filtered pins even during clear, so releasing
  // clear never produces a step from stale history.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ab_r <= 2'b00;
    end else begin
      prev_ab_r <= filt_r;
    end
  end

  // Position, direction and illegal-transition bookkeeping; clear beats a step.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r   <= 32'h0000_0000;
      dir_r     <= 1'b0;
      err_r     <= 1'b0;
      err_cnt_r <= 8'h00;
    end else if (bus.clear) begin
      count_r   <= 32'h0000_0000;
      err_r     <= 1'b0;
      err_cnt_r <= 8'h00;
    end else if (illegal_s) begin
      err_r <= 1'b1;
      if (err_cnt_r != 8'hFF) begin
        err_cnt_r <= err_cnt_r + 8'h01;
      end
    end else if (step_valid_s) begin
      count_r <= count_r + step_s;
      dir_r   <= up_s;
    end
  end

  // Velocity window: the step landing on the final window cycle is folded
  // straight into the published value rather than into the accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      velocity_r  <= 32'h0000_0000;
      acc_r       <= 32'h0000_0000;
      win_r       <= '0;
      vel_valid_r <= 1'b0;
    end else if (bus.clear) begin
      velocity_r  <= 32'h0000_0000;
      acc_r       <= 32'h0000_0000;
      win_r       <= '0;
      vel_valid_r <= 1'b0;
    end else if (win_r == WIN_LAST) begin
      velocity_r  <= acc_r + step_s;
      acc_r       <= 32'h0000_0000;
      win_r       <= '0;
      vel_valid_r <= 1'b1;
    end else begin
      acc_r       <= acc_r + step_s;
      win_r       <= win_r + WCW'(1);
      vel_valid_r <= 1'b0;
    end
  end

  assign bus.count     = count_r;
  assign bus.velocity  = velocity_r;
  assign bus.vel_valid = vel_valid_r;
  assign bus.dir       = dir_r;
  assign bus.err       = err_r;
  assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// -----------------------------------------------------------------------------
// tb_quad_encoder_counter
//   Directed scenarios followed by randomized stimulus. The reference model
//   works at the level of commanded steps: every pin change the bench makes is
//   classified (forward / reverse / illegal / rejected glitch) and scheduled to
//   land FILTER_LEN+3 cycles later; the model then applies position, window
//   and clear rules with plain arithmetic. All outputs are checked each cycle.
// -----------------------------------------------------------------------------
module tb_quad_encoder_counter;

  localparam int FL  = 4;
  localparam int VW  = 100;
  localparam bit INV = 1'b0;
  localparam int LAT = FL + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ab;
  logic       clr;

  always #5 clk = ~clk;

  quad_encoder_counter_if bus ();
  assign bus.enc_a = ab[1];
  assign bus.enc_b = ab[0];
  assign bus.clear = clr;

  quad_encoder_counter #(
    .FILTER_LEN (FL),
    .VEL_WINDOW (VW),
    .INVERT_DIR (INV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int landing;
    int delta;
    bit illegal;
  } ev_t;

  ev_t         evq [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          ph    = 0;
  logic [31:0] m_count, m_vel, m_acc;
  logic        m_vv, m_dir, m_err;
  int          m_errcnt, m_win_n;
  logic [31:0] saved;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pos_of(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit c);
    int d = 0;
    bit ill = 1'b0;
    for (int i = evq.size() - 1; i >= 0; i--) begin
      if (evq[i].landing == cyc) begin
        d   += evq[i].delta;
        ill |= evq[i].illegal;
        evq.delete(i);
      end
    end
    if (r) begin
      m_count = 0; m_vel = 0; m_acc = 0; m_vv = 0; m_dir = 0;
      m_err = 0; m_errcnt = 0; m_win_n = 0;
      evq.delete();
    end else begin
      m_vv = 1'b0;
      if (c) begin
        m_count = 0; m_vel = 0; m_acc = 0; m_err = 0; m_errcnt = 0; m_win_n = 0;
      end else begin
        if (ill) begin
          m_err = 1'b1;
          if (m_errcnt < 255) m_errcnt++;
          d = 0;
        end else if (d != 0) begin
          m_count = m_count + 32'(d);
          m_dir   = (d > 0);
        end
        m_win_n++;
        if (m_win_n % VW == 0) begin
          m_vel = m_acc + 32'(d);
          m_acc = 0;
          m_vv  = 1'b1;
        end else begin
          m_acc = m_acc + 32'(d);
        end
      end
    end
  endtask

  task automatic tick();
    bit r = reset;
    bit c = clr;
    @(posedge clk);
    #1;
    cyc++;
    model_step(r, c);
    check_val("count",     bus.count,         m_count);
    check_val("velocity",  bus.velocity,      m_vel);
    check_val("vel_valid", 32'(bus.vel_valid), 32'(m_vv));
    check_val("dir",       32'(bus.dir),      32'(m_dir));
    check_val("err",       32'(bus.err),      32'(m_err));
    check_val("err_cnt",   32'(bus.err_cnt),  32'(m_errcnt));
  endtask

  // Changes the pins now; if the change will survive the filter, schedule
  // its effect for LAT cycles later.
  task automatic set_ab(input logic [1:0] nv, input bit survives);
    int d = (pos_of(nv) - pos_of(ab) + 4) % 4;
    ev_t e;
    if (survives && d != 0) begin
      e.landing = cyc + LAT;
      e.illegal = (d == 2);
      e.delta   = (d == 1) ? 1 : ((d == 3) ? -1 : 0);
      if (INV) e.delta = -e.delta;
      evq.push_back(e);
    end
    ab = nv;
  endtask

  task automatic step_fwd(input int gap);
    ph = (ph + 1) & 3; set_ab(ab_of(ph), 1'b1); repeat (gap) tick();
  endtask
  task automatic step_rev(input int gap);
    ph = (ph + 3) & 3; set_ab(ab_of(ph), 1'b1); repeat (gap) tick();
  endtask
  task automatic step_ill(input int gap);
    ph = (ph + 2) & 3; set_ab(ab_of(ph), 1'b1); repeat (gap) tick();
  endtask

  task automatic pulse_a(input int width, input int settle);
    bit keep = (width >= FL);
    set_ab(ab ^ 2'b10, keep);
    repeat (width) tick();
    set_ab(ab ^ 2'b10, keep);
    repeat (settle) tick();
  endtask

  initial begin
    int k;
    reset = 1'b1; clr = 1'b0; ab = 2'b00;
    m_count = 0; m_vel = 0; m_acc = 0; m_vv = 0; m_dir = 0;
    m_err = 0; m_errcnt = 0; m_win_n = 0;
    repeat (3) tick();
    check_val("reset_count", bus.count, 32'h0);
    reset = 1'b0;
    repeat (5) tick();

    // Forward X4 cycles with exact first-update latency.
    ph = 1; set_ab(ab_of(ph), 1'b1);
    repeat (LAT - 1) tick();
    check_val("lat_before", bus.count, 32'd0);
    tick();
    check_val("lat_at", bus.count, 32'd1);
    repeat (10 - LAT) tick();
    for (int i = 0; i < 31; i++) step_fwd(10);
    check_val("fwd_count", bus.count, 32'd32);
    check_val("fwd_dir", 32'(bus.dir), 32'd1);
    check_val("fwd_err", 32'(bus.err), 32'd0);

    // Reverse, then walk down through zero.
    for (int i = 0; i < 5; i++) step_rev(10);
    check_val("rev_count", bus.count, 32'd27);
    check_val("rev_dir", 32'(bus.dir), 32'd0);
    clr = 1'b1; repeat (3) tick(); clr = 1'b0; tick();
    step_fwd(10);
    check_val("near0_count", bus.count, 32'd1);
    step_rev(10);
    check_val("zero_count", bus.count, 32'd0);
    step_rev(10);
    check_val("wrap_count", bus.count, 32'hFFFF_FFFF);

    // Glitch rejection and minimum accepted pulse.
    saved = bus.count;
    pulse_a(3, 12);
    check_val("glitch_count", bus.count, saved);
    pulse_a(4, 12);
    check_val("pulse_count", bus.count, saved);
    check_val("pulse_err", 32'(bus.err), 32'd0);

    // Illegal double transitions and saturation.
    step_ill(10);
    check_val("ill_count", bus.count, saved);
    check_val("ill_err", 32'(bus.err), 32'd1);
    check_val("ill_err_cnt", 32'(bus.err_cnt), 32'd1);
    for (int i = 0; i < 299; i++) step_ill(10);
    check_val("ill_sat", 32'(bus.err_cnt), 32'd255);

    // Velocity windows aligned to clear release.
    clr = 1'b1; repeat (2) tick(); clr = 1'b0;
    k = cyc;
    for (int i = 0; i < 20; i++) step_fwd(4);
    repeat (k + VW - 1 - cyc) tick();
    check_val("vel_early", 32'(bus.vel_valid), 32'd0);
    tick();
    check_val("vel_pulse", 32'(bus.vel_valid), 32'd1);
    check_val("vel_fwd", bus.velocity, 32'd20);
    for (int i = 0; i < 5; i++) step_rev(4);
    repeat (k + 2 * VW - cyc) tick();
    check_val("vel_rev", bus.velocity, 32'hFFFF_FFFB);
    check_val("vel_pulse2", 32'(bus.vel_valid), 32'd1);

    // Clear during stepping, then release.
    step_fwd(10); step_fwd(10);
    clr = 1'b1;
    for (int i = 0; i < 3; i++) step_fwd(10);
    check_val("clr_count", bus.count, 32'd0);
    check_val("clr_err", 32'(bus.err), 32'd0);
    clr = 1'b0;
    repeat (10) tick();
    check_val("clr_release", bus.count, 32'd0);
    step_fwd(10);
    check_val("clr_step", bus.count, 32'd1);

    // Reset mid-window with pins parked at 00.
    while (ph != 0) step_fwd(8);
    repeat (37) tick();
    reset = 1'b1; repeat (2) tick(); reset = 1'b0;
    check_val("midreset_count", bus.count, 32'd0);
    repeat (3) tick();

    // Randomized operations.
    for (int i = 0; i < 250; i++) begin
      int op  = int'($urandom_range(0, 9));
      int gap = int'($urandom_range(5, 9));
      case (op)
        0, 1, 2, 3: step_fwd(gap);
        4, 5, 6:    step_rev(gap);
        7:          step_ill(gap);
        8:          pulse_a(int'($urandom_range(1, 6)), gap);
        default: begin
          clr = 1'b1;
          repeat (int'($urandom_range(1, 20))) tick();
          clr = 1'b0;
          repeat (gap) tick();
        end
      endcase
    end
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
